alu_issue_ctrl: RTL

Initiator side of the ALU interface. Accepts decoded instruction fields and register operands over a valid/ready handshake, selects operands and the 3-bit ALU operation code, and drives the combinational ALU. It then captures result and zero into a registered response, resolves beq/bne, and holds the response until the consumer accepts it. Sits between register-file read and writeback in the multicycle datapath.

---
 rtl/alu_issue_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU interface in the multicycle
// datapath. Accepts one decoded instruction, drives the external
// combinational ALU for one cycle from registered fields, captures the
// result with branch/illegal flags and holds it until the consumer accepts.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              branch_taken,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;

    state_t state, state_next;

    logic [5:0]        opcode_q;
    logic [5:0]        funct_q;
    logic [4:0]        shamt_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [15:0]       imm_q;

    logic [2:0]        dec_ctrl;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic              dec_illegal;
    logic              dec_beq;
    logic              dec_bne;

    logic [DATA_W-1:0] shamt_ext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt_q};
    assign imm_sext  = {{(DATA_W-16){imm_q[15]}}, imm_q};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, imm_q};

    // Decode the registered instruction fields into ALU operands and op code.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can leave it unassigned (no latches).
        dec_ctrl    = ALU_ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        unique case (opcode_q)
            OP_RTYPE: begin
                unique case (funct_q)
                    FN_ADD: begin dec_ctrl = ALU_ADD; dec_a = rs_q; dec_b = rt_q;      end
                    FN_SUB: begin dec_ctrl = ALU_SUB; dec_a = rs_q; dec_b = rt_q;      end
                    FN_AND: begin dec_ctrl = ALU_AND; dec_a = rs_q; dec_b = rt_q;      end
                    FN_OR:  begin dec_ctrl = ALU_OR;  dec_a = rs_q; dec_b = rt_q;      end
                    FN_SLL: begin dec_ctrl = ALU_SLL; dec_a = rt_q; dec_b = shamt_ext; end
                    FN_SRL: begin dec_ctrl = ALU_SRL; dec_a = rt_q; dec_b = shamt_ext; end
                    FN_SRA: begin dec_ctrl = ALU_SRA; dec_a = rt_q; dec_b = shamt_ext; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin dec_ctrl = ALU_ADD; dec_a = rs_q; dec_b = imm_sext; end
            OP_ANDI: begin dec_ctrl = ALU_AND; dec_a = rs_q; dec_b = imm_zext; end
            OP_BEQ:  begin dec_ctrl = ALU_SUB; dec_a = rs_q; dec_b = rt_q; dec_beq = 1'b1; end
            OP_BNE:  begin dec_ctrl = ALU_SUB; dec_a = rs_q; dec_b = rt_q; dec_bne = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and handshake / ALU-drive outputs.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = EXEC;
            end
            EXEC: begin
                alu_a       = dec_a;
                alu_b       = dec_b;
                alu_control = dec_ctrl;
                state_next  = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture instruction fields and operands on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the operand registers are ordinary flops, so clearing them
        // on reset is cheap and keeps alu_a/alu_b deterministic afterwards.
        if (reset) begin
            opcode_q <= '0;
            funct_q  <= '0;
            shamt_q  <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
        end else if (instr_valid && instr_ready) begin
            // NOTE: sequential state is always updated with <= so every flop
            // samples the pre-edge values, independent of statement order.
            opcode_q <= opcode;
            funct_q  <= funct;
            shamt_q  <= shamt;
            rs_q     <= rs_data;
            rt_q     <= rt_data;
            imm_q    <= imm;
        end
    end

    // Register the response at the end of EXEC; it is held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data     <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else if (state == EXEC) begin
            res_data     <= dec_illegal ? '0 : alu_result;
            branch_taken <= (dec_beq && alu_zero) || (dec_bne && !alu_zero);
            illegal      <= dec_illegal;
        end
    end

    // Count accepted responses; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       retired_count <= '0;
        else if (res_valid && res_ready) retired_count <= retired_count + 1'b1;
    end

endmodule
